// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse key front-end and the
// letter decoder that consumes its code words.
package morse_pkg;

  localparam int CODE_W      = 8;
  localparam int MAX_SYMBOLS = 4;

  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    GAP,
    EMIT,
    STROBE,
    CLEAR
  } state_e;

endpackage

// File: rtl/morse_key_sync.sv
// Two-flop synchroniser bringing the raw key input into the clk domain.
module morse_key_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/morse_key_sequencer.sv
// Key front-end: times presses and gaps on the synchronised key, packs up to
// four dot/dash symbols into a code word and strobes it out once per letter.
module morse_key_sequencer
  import morse_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MIN_PRESS  = 4,
  parameter int DOT_MAX    = 20,
  parameter int LETTER_GAP = 60,
  parameter int READY_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_in,
  output logic [CODE_W-1:0] morse_array,
  output logic              new_input_ready,
  output logic [2:0]        symbol_count,
  output logic              busy,
  output logic              overflow_err
);

  localparam int STB_W = (READY_W > 1) ? $clog2(READY_W) : 1;

  logic              key_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CODE_W-1:0] shift_q, shift_d;
  logic [2:0]        sym_cnt_q, sym_cnt_d;
  logic              ovf_q, ovf_d;
  logic [CODE_W-1:0] morse_q, morse_d;
  logic [STB_W-1:0]  strobe_cnt_q, strobe_cnt_d;

  logic              press_short;
  logic [1:0]        sym;
  logic [CNT_W-1:0]  gap_inc;

  morse_key_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_s)
  );

  assign press_short = (press_cnt_q < CNT_W'(MIN_PRESS));
  assign sym         = (press_cnt_q <= CNT_W'(DOT_MAX)) ? SYM_DOT : SYM_DASH;
  assign gap_inc     = gap_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      press_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      shift_q      <= '0;
      sym_cnt_q    <= '0;
      ovf_q        <= 1'b0;
      morse_q      <= '0;
      strobe_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      press_cnt_q  <= press_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      shift_q      <= shift_d;
      sym_cnt_q    <= sym_cnt_d;
      ovf_q        <= ovf_d;
      morse_q      <= morse_d;
      strobe_cnt_q <= strobe_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    press_cnt_d  = press_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    shift_d      = shift_q;
    sym_cnt_d    = sym_cnt_q;
    ovf_d        = ovf_q;
    morse_d      = morse_q;
    strobe_cnt_d = strobe_cnt_q;

    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d     = PRESS;
          press_cnt_d = CNT_W'(1);
        end
      end

      PRESS: begin
        if (key_s) begin
          if (press_cnt_q != '1)
            press_cnt_d = press_cnt_q + 1'b1;
        end else if (press_short) begin
          // a glitch keeps the running gap count so it cannot stretch a letter
          state_d = (sym_cnt_q == 3'd0) ? IDLE : GAP;
        end else begin
          if (sym_cnt_q < 3'(MAX_SYMBOLS)) begin
            shift_d   = {shift_q[CODE_W-3:0], sym};
            sym_cnt_d = sym_cnt_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d   = GAP;
          gap_cnt_d = '0;
        end
      end

      GAP: begin
        if (key_s) begin
          state_d     = PRESS;
          press_cnt_d = CNT_W'(1);
        end else begin
          gap_cnt_d = gap_inc;
          if (gap_inc == CNT_W'(LETTER_GAP)) begin
            state_d = EMIT;
            // load here so the word is settled for the whole EMIT cycle
            if (!ovf_q)
              morse_d = shift_q;
          end
        end
      end

      EMIT: begin
        if (ovf_q) begin
          state_d = CLEAR;
        end else begin
          state_d      = STROBE;
          strobe_cnt_d = STB_W'(READY_W - 1);
        end
      end

      STROBE: begin
        if (strobe_cnt_q == '0)
          state_d = CLEAR;
        else
          strobe_cnt_d = strobe_cnt_q - 1'b1;
      end

      CLEAR: begin
        shift_d   = '0;
        sym_cnt_d = '0;
        ovf_d     = 1'b0;
        gap_cnt_d = '0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    new_input_ready = (state_q == STROBE);
    busy            = (state_q != IDLE);
    overflow_err    = (state_q == EMIT) && ovf_q;
    morse_array     = morse_q;
    symbol_count    = sym_cnt_q;
  end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Self-checking bench for morse_key_sequencer: directed letters, glitch,
// overflow, saturation and reset cases plus randomized letters vs a model.
module tb_morse_key_sequencer;

  localparam int CNT_W      = 16;
  localparam int MIN_PRESS  = 4;
  localparam int DOT_MAX    = 20;
  localparam int LETTER_GAP = 60;
  localparam int READY_W    = 2;
  // release-to-ready in key_in cycles: letter latency plus the synchroniser
  localparam int LAT_EXP    = LETTER_GAP + 2 + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b0;
  logic [7:0] morse_array;
  logic       new_input_ready;
  logic [2:0] symbol_count;
  logic       busy;
  logic       overflow_err;

  int checks   = 0;
  int failures = 0;

  int ready_rises = 0;
  int ovf_pulses  = 0;
  logic ready_prev = 1'b0;

  int durs[8];
  int gaps[8];
  int npress;

  morse_key_sequencer #(
    .CNT_W      (CNT_W),
    .MIN_PRESS  (MIN_PRESS),
    .DOT_MAX    (DOT_MAX),
    .LETTER_GAP (LETTER_GAP),
    .READY_W    (READY_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .key_in          (key_in),
    .morse_array     (morse_array),
    .new_input_ready (new_input_ready),
    .symbol_count    (symbol_count),
    .busy            (busy),
    .overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_input_ready && !ready_prev) ready_rises++;
    if (overflow_err) ovf_pulses++;
    ready_prev = new_input_ready;
  end

  task automatic key_press(input int dur);
    key_in = 1'b1;
    repeat (dur) @(negedge clk);
    key_in = 1'b0;
  endtask

  task automatic key_idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_letter();
    for (int i = 0; i < npress; i++) begin
      key_press(durs[i]);
      if (i < npress - 1) key_idle(gaps[i]);
    end
  endtask

  // Measures one strobe starting from the release negedge.
  task automatic wait_strobe(output bit seen, output int lat, output int width,
                             output logic [7:0] code, output bit stable);
    logic [7:0] prev;
    seen = 0; lat = 0; width = 0; code = '0; stable = 0;
    prev = morse_array;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (new_input_ready) begin
        seen   = 1;
        code   = morse_array;
        stable = (prev == morse_array);
      end else begin
        prev = morse_array;
      end
    end
    if (seen) begin
      while (new_input_ready && width < 20) begin
        width++;
        @(negedge clk);
      end
    end
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
  endtask

  // Letter code from press durations: glitches vanish, first symbol ends up
  // most significant, nothing past the fourth symbol is kept.
  function automatic logic [7:0] model_code();
    int code = 0;
    int nv = 0;
    for (int i = 0; i < npress; i++) begin
      if (durs[i] >= MIN_PRESS) begin
        nv++;
        if (nv <= 4) code = code * 4 + ((durs[i] <= DOT_MAX) ? 1 : 2);
      end
    end
    return 8'(code);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    key_in = 1'b0;
    key_idle(3);
    checks++; if (morse_array !== 8'h00) begin failures++; $display("FAIL reset_morse got=%h exp=00", morse_array); end
    checks++; if (new_input_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", new_input_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow_err); end
    checks++; if (symbol_count !== 3'd0) begin failures++; $display("FAIL reset_symcnt got=%0d exp=0", symbol_count); end
    rst = 1'b0;
    key_idle(3);
  endtask

  task automatic test_letter_a();
    bit seen, stable; int lat, width; logic [7:0] code;
    key_press(10);
    key_idle(5);
    checks++; if (symbol_count !== 3'd1) begin failures++; $display("FAIL a_symcnt_mid got=%0d exp=1", symbol_count); end
    key_idle(25);
    key_press(30);
    wait_strobe(seen, lat, width, code, stable);
    checks++; if (!seen) begin failures++; $display("FAIL a_strobe_seen got=0 exp=1"); end
    checks++; if (code !== 8'b00000110) begin failures++; $display("FAIL a_code got=%b exp=00000110", code); end
    checks++; if (lat != LAT_EXP) begin failures++; $display("FAIL a_latency got=%0d exp=%0d", lat, LAT_EXP); end
    checks++; if (width != READY_W) begin failures++; $display("FAIL a_width got=%0d exp=%0d", width, READY_W); end
    checks++; if (!stable) begin failures++; $display("FAIL a_stable_before_ready got=0 exp=1"); end
    checks++; if (symbol_count !== 3'd0) begin failures++; $display("FAIL a_symcnt_after got=%0d exp=0", symbol_count); end
    key_idle(5);
  endtask

  task automatic test_letter_b();
    bit seen, stable; int lat, width; logic [7:0] code; int r0;
    r0 = ready_rises;
    npress = 4;
    durs[0] = 30; durs[1] = 10; durs[2] = 10; durs[3] = 10;
    gaps[0] = 15; gaps[1] = 15; gaps[2] = 15;
    send_letter();
    wait_strobe(seen, lat, width, code, stable);
    key_idle(40);
    checks++; if (code !== 8'b10010101) begin failures++; $display("FAIL b_code got=%b exp=10010101", code); end
    checks++; if (ready_rises - r0 != 1) begin failures++; $display("FAIL b_strobe_count got=%0d exp=1", ready_rises - r0); end
    checks++; if (lat != LAT_EXP) begin failures++; $display("FAIL b_latency got=%0d exp=%0d", lat, LAT_EXP); end
  endtask

  task automatic test_glitch();
    logic [7:0] m0; int r0; int t;
    m0 = morse_array;
    r0 = ready_rises;
    key_press(2);
    t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 8);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_clear got=%b exp=0", busy); end
    key_idle(100);
    checks++; if (ready_rises != r0) begin failures++; $display("FAIL glitch_no_strobe got=%0d exp=%0d", ready_rises, r0); end
    checks++; if (morse_array !== m0) begin failures++; $display("FAIL glitch_morse got=%h exp=%h", morse_array, m0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_overflow();
    bit seen, stable; int lat, width; logic [7:0] code; logic [7:0] m0; int r0, o0;
    m0 = morse_array;
    r0 = ready_rises;
    o0 = ovf_pulses;
    npress = 5;
    for (int i = 0; i < 5; i++) begin durs[i] = 10; gaps[i] = 15; end
    send_letter();
    key_idle(120);
    checks++; if (ovf_pulses - o0 != 1) begin failures++; $display("FAIL ovf_pulse_count got=%0d exp=1", ovf_pulses - o0); end
    checks++; if (ready_rises != r0) begin failures++; $display("FAIL ovf_no_strobe got=%0d exp=%0d", ready_rises, r0); end
    checks++; if (morse_array !== m0) begin failures++; $display("FAIL ovf_morse_kept got=%h exp=%h", morse_array, m0); end
    checks++; if (symbol_count !== 3'd0 || busy !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%0d/%b exp=0/0", symbol_count, busy); end
    npress = 1; durs[0] = 10;
    send_letter();
    wait_strobe(seen, lat, width, code, stable);
    checks++; if (!seen || code !== 8'b00000001) begin failures++; $display("FAIL ovf_next_e got=%b seen=%0d exp=00000001", code, seen); end
    key_idle(5);
  endtask

  task automatic test_random_letters();
    bit seen, stable; int lat, width; logic [7:0] code, exp;
    int nsym, glitch_at, ghi;
    for (int n = 0; n < 10; n++) begin
      nsym = $urandom_range(1, 4);
      glitch_at = (nsym >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, nsym - 1) : -1;
      ghi = (glitch_at >= 0) ? 20 : 30;
      npress = 0;
      for (int s = 0; s < nsym; s++) begin
        if (s == glitch_at) begin
          durs[npress] = $urandom_range(1, MIN_PRESS - 1);
          gaps[npress] = $urandom_range(5, ghi);
          npress++;
        end
        case ($urandom_range(0, 3))
          0: durs[npress] = MIN_PRESS;
          1: durs[npress] = DOT_MAX;
          2: durs[npress] = DOT_MAX + 1;
          default: durs[npress] = $urandom_range(MIN_PRESS, 45);
        endcase
        gaps[npress] = $urandom_range(5, ghi);
        npress++;
      end
      exp = model_code();
      send_letter();
      wait_strobe(seen, lat, width, code, stable);
      checks++; if (!seen) begin failures++; $display("FAIL rnd%0d_seen got=0 exp=1", n); end
      checks++; if (code !== exp) begin failures++; $display("FAIL rnd%0d_code got=%b exp=%b", n, code, exp); end
      checks++; if (lat != LAT_EXP) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, lat, LAT_EXP); end
      checks++; if (width != READY_W) begin failures++; $display("FAIL rnd%0d_width got=%0d exp=%0d", n, width, READY_W); end
      checks++; if (!stable) begin failures++; $display("FAIL rnd%0d_stable got=0 exp=1", n); end
      key_idle($urandom_range(2, 10));
    end
  endtask

  task automatic test_press_during_strobe();
    bit seen, stable; int lat, width; logic [7:0] code; int t;
    npress = 1; durs[0] = 30;
    send_letter();
    t = 0;
    do begin @(negedge clk); t++; end while (!new_input_ready && t < 200);
    checks++; if (!new_input_ready) begin failures++; $display("FAIL pds_first_strobe got=0 exp=1"); end
    // held 21 cycles, but only the part after returning to IDLE counts: a dot
    key_press(21);
    wait_strobe(seen, lat, width, code, stable);
    checks++; if (!seen || code !== 8'b00000001) begin failures++; $display("FAIL pds_code got=%b seen=%0d exp=00000001", code, seen); end
    checks++; if (lat != LAT_EXP) begin failures++; $display("FAIL pds_latency got=%0d exp=%0d", lat, LAT_EXP); end
    key_idle(5);
  endtask

  task automatic test_saturation();
    bit seen, stable; int lat, width; logic [7:0] code;
    key_press(66000);
    wait_strobe(seen, lat, width, code, stable);
    checks++; if (!seen || code !== 8'b00000010) begin failures++; $display("FAIL sat_code got=%b seen=%0d exp=00000010", code, seen); end
    key_idle(5);
  endtask

  task automatic test_reset_mid_strobe();
    int t, r0;
    npress = 1; durs[0] = 10;
    send_letter();
    t = 0;
    do begin @(negedge clk); t++; end while (!new_input_ready && t < 200);
    checks++; if (!new_input_ready) begin failures++; $display("FAIL rms_strobe_reached got=0 exp=1"); end
    #1 rst = 1'b1;
    #1;
    checks++; if (new_input_ready !== 1'b0) begin failures++; $display("FAIL rms_ready_async got=%b exp=0", new_input_ready); end
    checks++; if (morse_array !== 8'h00) begin failures++; $display("FAIL rms_morse got=%h exp=00", morse_array); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rms_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    r0 = ready_rises;
    key_idle(100);
    checks++; if (ready_rises != r0) begin failures++; $display("FAIL rms_no_strobe got=%0d exp=%0d", ready_rises, r0); end
    checks++; if (busy !== 1'b0 || morse_array !== 8'h00) begin failures++; $display("FAIL rms_idle got=%b/%h exp=0/00", busy, morse_array); end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_letter_b();
    test_glitch();
    test_overflow();
    test_random_letters();
    test_press_during_strobe();
    test_saturation();
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
